flash_tx_buffer: RTL and testbench

FLASH_TX_BUFFER -- requirements
Module: flash_tx_buffer

---
 rtl/flash_tx_buffer.sv | 160 ++++++++++++++++
 tb/tb_flash_tx_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_tx_buffer.sv
// Byte FIFO between the flash SPI read path and a UART transmitter.
// Registered occupancy flags and a small FSM that re-strobes tx_start if the UART never goes busy.
module flash_tx_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     mydata_i,
  input  logic                  myvalid_i,
  input  logic                  flush,
  input  logic                  clr_ovf,
  input  logic                  tx_ready,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_start,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [15:0]           tx_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    empty_q, empty_d;
  logic                    full_q, full_d;
  logic                    overflow_q, overflow_d;
  logic [15:0]             tx_count_q, tx_count_d;
  logic                    tx_start_q, tx_start_d;
  logic [DATA_W-1:0]       tx_data_q, tx_data_d;
  logic [1:0]              wb_cnt_q, wb_cnt_d;
  logic                    retx_q, retx_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic                    pop_s;
  logic                    push_s;

  // A pop frees the head slot in the same cycle, so a write into a full FIFO is legal alongside it.
  assign pop_s  = (state_q == IDLE) && !empty_q && tx_ready && !flush;
  assign push_s = myvalid_i && (!full_q || pop_s) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_count_q <= 16'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      wb_cnt_q   <= 2'd0;
      retx_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      tx_count_q <= tx_count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      wb_cnt_q   <= wb_cnt_d;
      retx_q     <= retx_d;
    end
  end

  // Storage carries no reset; contents are meaningless once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= mydata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop_s) state_d = LOAD;
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_ready)              state_d = WAIT_DONE;
        else if (wb_cnt_q == 2'd3)  state_d = LOAD;
        else                        state_d = WAIT_BUSY;
      end
      WAIT_DONE: if (tx_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    tx_count_d = tx_count_q;
    tx_data_d  = tx_data_q;
    retx_d     = retx_q;
    wb_cnt_d   = 2'd0;
    tx_start_d = (state_q == LOAD) && !flush;

    if (push_s) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_s) begin
      rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end
    if (push_s && !pop_s)      level_d = level_q + LVL_W'(1);
    else if (pop_s && !push_s) level_d = level_q - LVL_W'(1);
    else                       level_d = level_q;

    // A drop in the same cycle as clr_ovf keeps the flag set.
    if (myvalid_i && full_q && !pop_s && !flush) overflow_d = 1'b1;
    else if (clr_ovf)                            overflow_d = 1'b0;
    else                                         overflow_d = overflow_q;

    // Re-strobes from WAIT_BUSY resend the same byte and are not counted again.
    if (state_q == LOAD && !retx_q) tx_count_d = tx_count_q + 16'd1;
    if (state_q == IDLE)                                retx_d = 1'b0;
    else if (state_q == WAIT_BUSY && state_d == LOAD)   retx_d = 1'b1;
    else                                                retx_d = retx_q;
    if (state_q == WAIT_BUSY && tx_ready) wb_cnt_d = wb_cnt_q + 2'd1;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      tx_count_d = 16'd0;
      retx_d     = 1'b0;
      wb_cnt_d   = 2'd0;
    end
    empty_d = (level_d == LVL_W'(0));
    full_d  = (level_d == LVL_W'(DEPTH));
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign level    = level_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;
  assign tx_count = tx_count_q;

endmodule

// File: tb/tb_flash_tx_buffer.sv
// Directed bench for flash_tx_buffer: latency, re-strobe, overflow, full write+pop, flush and reset abort.
module tb_flash_tx_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mydata_i;
  logic        myvalid_i;
  logic        flush;
  logic        clr_ovf;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic        overflow;
  logic [15:0] tx_count;

  int checks = 0;
  int errors = 0;

  flash_tx_buffer #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .mydata_i(mydata_i), .myvalid_i(myvalid_i),
    .flush(flush), .clr_ovf(clr_ovf), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .level(level), .empty(empty),
    .full(full), .overflow(overflow), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One write strobe; called and returns on a falling edge.
  task automatic push_byte(input logic [7:0] d);
    myvalid_i = 1'b1;
    mydata_i  = d;
    @(negedge clk);
    myvalid_i = 1'b0;
  endtask

  // Wait for a strobe, check the byte, then act as a UART going busy and idle again.
  task automatic recv(input logic [7:0] exp, input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (tx_start === 1'b1) found = 1'b1;
    end
    check({tag, "_seen"}, {31'd0, found}, 32'd1);
    check({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
    tx_ready = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mydata_i = 8'h00; myvalid_i = 1'b0; flush = 1'b0;
    clr_ovf = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_level", {27'd0, level}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_start", {31'd0, tx_start}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_count", {16'd0, tx_count}, 32'd0);
    rst = 1'b0;

    // Single byte latency, then UART never goes busy: re-strobe every 5 cycles.
    tx_ready = 1'b1;
    push_byte(8'hA5);
    check("lat_c1_start", {31'd0, tx_start}, 32'd0);
    check("lat_c1_level", {27'd0, level}, 32'd1);
    check("lat_c1_empty", {31'd0, empty}, 32'd0);
    @(negedge clk);
    check("lat_c2_start", {31'd0, tx_start}, 32'd0);
    check("lat_c2_data", {24'd0, tx_data}, 32'hA5);
    @(negedge clk);
    check("lat_c3_start", {31'd0, tx_start}, 32'd1);
    check("lat_c3_count", {16'd0, tx_count}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rep_gap_start", {31'd0, tx_start}, 32'd0);
    end
    @(negedge clk);
    check("rep_start", {31'd0, tx_start}, 32'd1);
    check("rep_data", {24'd0, tx_data}, 32'hA5);
    check("rep_count", {16'd0, tx_count}, 32'd1);
    tx_ready = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    check("rep_after_start", {31'd0, tx_start}, 32'd0);

    // Fill 17 bytes with UART busy: last one dropped.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    check("ovf_level", {27'd0, level}, 32'd16);
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    clr_ovf = 1'b1;
    push_byte(8'hEE);
    clr_ovf = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    check("ovf_level_hold", {27'd0, level}, 32'd16);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) recv(8'(i), "drain");
    check("drain_count", {16'd0, tx_count}, 32'd16);
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Full FIFO, write and pop on the same edge.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    check("wp_full_before", {31'd0, full}, 32'd1);
    tx_ready = 1'b1;
    push_byte(8'h55);
    check("wp_level", {27'd0, level}, 32'd16);
    check("wp_full", {31'd0, full}, 32'd1);
    check("wp_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 16; i++) recv(8'h20 + 8'(i), "wp_drain");
    recv(8'h55, "wp_last");
    check("wp_count", {16'd0, tx_count}, 32'd17);

    // Flush with a concurrent write.
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
    check("fl_level_pre", {27'd0, level}, 32'd5);
    flush = 1'b1;
    push_byte(8'h77);
    flush = 1'b0;
    check("fl_level", {27'd0, level}, 32'd0);
    check("fl_empty", {31'd0, empty}, 32'd1);
    check("fl_full", {31'd0, full}, 32'd0);
    check("fl_count", {16'd0, tx_count}, 32'd0);
    check("fl_start", {31'd0, tx_start}, 32'd0);
    check("fl_data_hold", {24'd0, tx_data}, 32'h55);
    tx_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("fl_idle_start", {31'd0, tx_start}, 32'd0);
    end
    check("fl_level_post", {27'd0, level}, 32'd0);

    // Reset while waiting for the UART to finish, three bytes still queued.
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'h31 + 8'(i));
    tx_ready = 1'b1;
    begin
      logic found;
      found = 1'b0;
      for (int n = 0; n < 30 && !found; n++) begin
        @(negedge clk);
        if (tx_start === 1'b1) found = 1'b1;
      end
      check("ra_seen", {31'd0, found}, 32'd1);
    end
    check("ra_data", {24'd0, tx_data}, 32'h31);
    tx_ready = 1'b0;
    @(negedge clk);
    check("ra_level", {27'd0, level}, 32'd3);
    rst = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ra_level0", {27'd0, level}, 32'd0);
    check("ra_empty", {31'd0, empty}, 32'd1);
    check("ra_count", {16'd0, tx_count}, 32'd0);
    check("ra_data0", {24'd0, tx_data}, 32'd0);
    check("ra_start", {31'd0, tx_start}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("ra_quiet", {31'd0, tx_start}, 32'd0);
    end
    push_byte(8'h3C);
    recv(8'h3C, "ra_new");
    check("ra_new_count", {16'd0, tx_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
